can_tx_frame_packer: RTL
========================

Name: can_tx_frame_packer

Overview:
- Transmit-side counterpart of the unbuffered byte-per-cycle CAN receive stream.
- Accepts a user byte stream tagged with ID/IDE and packs it into CAN data frames of up to 8 bytes.
- Drives the packet-level controller's transmit handshake (start/done/acked), with bounded retry.
- Sits between the user TX logic and the CAN packet-level controller.

Parameters:
- MAX_RETRY, 2, number of re-attempts after the first un-ACKed transmission before the frame is dropped (0..15).
- FLUSH_TIMEOUT, 1024, idle cycles with a partial frame and no new byte before the frame is closed; 0 disables the flush.

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous active-low reset
- in_valid  input  1  byte-stream valid
- in_ready  output  1  byte accepted when in_valid&&in_ready
- in_data  input  8  payload byte
- in_last  input  1  last byte of a user packet
- in_id  input  29  frame ID; [10:0] used when in_ide=0
- in_ide  input  1  1 = 29-bit ID, 0 = 11-bit ID
- tx_start  output  1  level request to the packet controller; held until the frame completes
- tx_id  output  29  ID of the frame being sent
- tx_ide  output  1  IDE of the frame being sent
- tx_len  output  4  DLC, 1..8
- tx_data  output  64  payload; byte0 in [63:56], unused bytes zero
- tx_done  input  1  one-cycle pulse: attempt finished
- tx_acked  input  1  qualifies tx_done: attempt was ACKed
- frame_sent  output  1  one-cycle pulse: frame ACKed
- frame_dropped  output  1  one-cycle pulse: retries exhausted
- busy  output  1  state != IDLE

Behaviour:
- Reset (rstn=0 at a clk edge):
  - State = IDLE.
  - in_ready=0, tx_start=0, tx_id=0, tx_ide=0, tx_len=0, tx_data=0, frame_sent=0, frame_dropped=0, busy=0.
  - Counters cleared.
  - Reset mid-transmission abandons the frame immediately; no frame_dropped pulse.
- States: IDLE, COLLECT, SEND.
- IDLE:
  - in_ready=1.
  - On an accepted byte: latch tx_ide=in_ide.
    - in_ide=0: tx_id={18'd0, in_id[10:0]}.
    - in_ide=1: tx_id=in_id.
  - Clear tx_data, then write the byte to [63:56] and set byte count=1.
  - If in_last=1, go to SEND with tx_len=1; else go to COLLECT.
- COLLECT:
  - in_ready=1.
  - Byte k (k = current count, 0-based) is written to tx_data[63-8k -: 8]; count increments.
  - in_id/in_ide on non-first bytes are ignored.
  - Frame closes on in_last, or when the 8th byte is accepted; close goes to SEND with tx_len = count.
  - A user packet longer than 8 bytes is split. The next byte starts a new frame from IDLE and re-latches ID/IDE.
  - Flush timer counts consecutive cycles with no accepted byte and resets on every accepted byte.
    - FLUSH_TIMEOUT != 0: reaching FLUSH_TIMEOUT goes to SEND with tx_len = count (>=1).
- SEND:
  - in_ready=0.
  - tx_start=1 from the first SEND cycle (registered, one cycle after close).
  - tx_id/ide/len/data are stable for the whole SEND.
  - retry_cnt is cleared on entry.
  - tx_done=1 with tx_acked=1: frame_sent pulses next cycle, tx_start=0, go to IDLE.
  - tx_done=1 with tx_acked=0:
    - retry_cnt==MAX_RETRY: frame_dropped pulses, tx_start=0, go to IDLE.
    - Otherwise: retry_cnt+1 and tx_start stays 1; the controller restarts.
  - tx_acked is ignored when tx_done=0. tx_done outside SEND is ignored.
- Registered outputs and latency:
  - All outputs are registered.
  - Minimum latency from the last accepted byte to tx_start=1 is 1 cycle.
  - Back-to-back frames have at least 1 IDLE cycle between tx_start deassert and the next frame accepting a byte.
- Width rules:
  - Byte count is 4 bits and saturates at 8.
  - retry_cnt is 4 bits.
  - The flush timer is sized to $clog2(FLUSH_TIMEOUT+1).

Test Plan:
- Reset, then 3 bytes 0x11,0x22,0x33 (last on 3rd), in_id=0x123, ide=0 -> tx_start=1 one cycle later; tx_len=3, tx_data=0x112233_0000000000, tx_id=0x123. Then tx_done with acked=1 -> frame_sent pulse, busy=0.
- 10-byte packet 0x01..0x0A, ide=1, id=0x12345678 -> frame 1 has len=8, data=0x0102030405060708. After its ACK, frame 2 has len=2, data=0x090A<<48, same ID re-latched.
- MAX_RETRY=2, three tx_done pulses with acked=0 -> tx_start held through all three, then frame_dropped pulse after the 3rd, busy=0.
- 2 bytes with no in_last, FLUSH_TIMEOUT=16 -> tx_start asserts after 16 idle cycles, tx_len=2. Any byte arriving before the count reaches 16 restarts the count.
- in_valid held during SEND -> in_ready=0 and no byte consumed. A stray tx_done while in IDLE -> no state change.
- rstn=0 during SEND with retry_cnt=1 -> next cycle all outputs are at reset values, no frame_dropped. A following frame sends normally.

Source files
------------

// File: rtl/can_tx_frame_packer.sv
// Packs a tagged user byte stream into CAN data frames of up to 8 bytes.
// Drives the packet controller's start/done/acked handshake and retries un-ACKed frames a bounded number of times.
module can_tx_frame_packer #(
   parameter int MAX_RETRY     = 2,
   parameter int FLUSH_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   input  logic [28:0] in_id,
   input  logic        in_ide,
   output logic        tx_start,
   output logic [28:0] tx_id,
   output logic        tx_ide,
   output logic [3:0]  tx_len,
   output logic [63:0] tx_data,
   input  logic        tx_done,
   input  logic        tx_acked,
   output logic        frame_sent,
   output logic        frame_dropped,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

   // A zero timeout still needs a 1-bit counter so the declaration stays legal.
   localparam int FW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);
   localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

   state_t        state, state_nxt;
   logic [3:0]    cnt, retry_cnt;
   logic [FW-1:0] flush_cnt;
   logic          acc, close, flush_hit, nack_final;
   logic          in_ready_d, tx_start_d, busy_d, sent_d, drop_d;

   assign acc        = in_valid && in_ready;
   assign close      = acc && (in_last || (state == COLLECT && cnt == 4'd7));
   assign flush_hit  = (FLUSH_TIMEOUT != 0) && (state == COLLECT) && !acc && (flush_cnt == FLUSH_LAST);
   assign nack_final = tx_done && !tx_acked && (retry_cnt == RETRY_MAX);

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc) state_nxt = close ? SEND : COLLECT;
         COLLECT: if (close || flush_hit) state_nxt = SEND;
         SEND:    if (tx_done && (tx_acked || nack_final)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready_d = (state_nxt != SEND);
      tx_start_d = (state_nxt == SEND);
      busy_d     = (state_nxt != IDLE);
      sent_d     = (state == SEND) && tx_done && tx_acked;
      drop_d     = (state == SEND) && nack_final;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         in_ready      <= 1'b0;
         tx_start      <= 1'b0;
         busy          <= 1'b0;
         frame_sent    <= 1'b0;
         frame_dropped <= 1'b0;
      end else begin
         in_ready      <= in_ready_d;
         tx_start      <= tx_start_d;
         busy          <= busy_d;
         frame_sent    <= sent_d;
         frame_dropped <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_id     <= '0;
         tx_ide    <= 1'b0;
         tx_len    <= '0;
         tx_data   <= '0;
         cnt       <= '0;
         retry_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (acc) begin
               tx_ide    <= in_ide;
               tx_id     <= in_ide ? in_id : {18'd0, in_id[10:0]};
               tx_data   <= {in_data, 56'd0};
               cnt       <= 4'd1;
               flush_cnt <= '0;
               retry_cnt <= '0;
               if (in_last) tx_len <= 4'd1;
            end
            COLLECT: begin
               retry_cnt <= '0;
               if (acc) begin
                  // Unused byte lanes are already zero, so OR-in at the byte offset.
                  tx_data   <= tx_data | ({in_data, 56'd0} >> {cnt[2:0], 3'b000});
                  cnt       <= (cnt == 4'd8) ? 4'd8 : cnt + 4'd1;
                  flush_cnt <= '0;
                  if (close) tx_len <= cnt + 4'd1;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
                  if (flush_hit) tx_len <= cnt;
               end
            end
            SEND: if (tx_done && !tx_acked && retry_cnt != RETRY_MAX) retry_cnt <= retry_cnt + 4'd1;
            default: ;
         endcase
      end
   end

endmodule
